// File: rtl/seq_control_unit_if.sv
// Decode/sequencer bundle between the IF/ID register and the control unit.
// The slave side is the control unit; the master side feeds opcodes and consumes controls.
interface seq_control_unit_if #(
   parameter int OPCODE_W = 8,
   parameter int PC_W     = 32,
   parameter int MEM_W    = 16
);
   localparam int PC_WORDS = PC_W / MEM_W;
   localparam int SEL_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;

   logic [OPCODE_W-1:0] opcode;
   logic                opcode_valid;
   logic                int_req;
   logic                wb;
   logic                alu;
   logic                imm;
   logic [2:0]          alu_ops;
   logic                mr;
   logic                mw;
   logic                jmp;
   logic [1:0]          flag_sel;
   logic                io_rd;
   logic                io_wr;
   logic                is_stack_op;
   logic                stack_op;
   logic                stack_pc;
   logic                stack_flags;
   logic [SEL_W-1:0]    pc_word_sel;
   logic                load_vector;
   logic                int_ack;
   logic                stall;
   logic                illegal;

   modport master (
      output opcode, opcode_valid, int_req,
      input  wb, alu, imm, alu_ops, mr, mw, jmp, flag_sel,
      input  io_rd, io_wr, is_stack_op, stack_op, stack_pc,
      input  stack_flags, pc_word_sel, load_vector, int_ack,
      input  stall, illegal
   );

   modport slave (
      input  opcode, opcode_valid, int_req,
      output wb, alu, imm, alu_ops, mr, mw, jmp, flag_sel,
      output io_rd, io_wr, is_stack_op, stack_op, stack_pc,
      output stack_flags, pc_word_sel, load_vector, int_ack,
      output stall, illegal
   );
endinterface

// File: rtl/seq_control_unit.sv
// Decode-stage control unit with a micro-step sequencer for
// interrupt entry, CALL, RET and RTI stack transfers.
module seq_control_unit #(
   parameter int OPCODE_W = 8,
   parameter int PC_W     = 32,
   parameter int MEM_W    = 16
) (
   input logic               clk,
   input logic               rst_n,
   seq_control_unit_if.slave bus
);
   localparam int PC_WORDS = PC_W / MEM_W;
   localparam int SEL_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(PC_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, CALL_PC, INT_PC, INT_FLG, INT_VEC, RET_PC, RTI_FLG
   } state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] word_cnt, word_cnt_nxt;
   logic             int_pend, int_pend_nxt;
   logic             pend_now, last_word, hi_zero;
   logic             pc_state;
   logic [1:0]       cls;
   logic [2:0]       grp, fn;

   assign cls       = bus.opcode[7:6];
   assign grp       = bus.opcode[5:3];
   assign fn        = bus.opcode[2:0];
   assign hi_zero   = (bus.opcode >> 8) == '0;
   assign pend_now  = int_pend | bus.int_req;
   assign last_word = word_cnt == LAST;
   assign pc_state  = (state == CALL_PC) || (state == INT_PC) ||
                      (state == RET_PC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         word_cnt <= '0;
         int_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         word_cnt <= word_cnt_nxt;
         int_pend <= int_pend_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      bus.wb          = 1'b0;
      bus.alu         = 1'b0;
      bus.imm         = 1'b0;
      bus.alu_ops     = 3'd0;
      bus.mr          = 1'b0;
      bus.mw          = 1'b0;
      bus.jmp         = 1'b0;
      bus.flag_sel    = 2'd0;
      bus.io_rd       = 1'b0;
      bus.io_wr       = 1'b0;
      bus.is_stack_op = 1'b0;
      bus.stack_op    = 1'b0;
      bus.stack_pc    = 1'b0;
      bus.stack_flags = 1'b0;
      bus.pc_word_sel = '0;
      bus.load_vector = 1'b0;
      bus.int_ack     = 1'b0;
      bus.illegal     = 1'b0;
      unique case (state)
         IDLE: begin
            // rst_n gate keeps every output low while reset is held
            if (bus.opcode_valid && rst_n) begin
               if (!hi_zero) begin
                  bus.illegal = 1'b1;
               end else begin
                  unique case (1'b1)
                     (grp == 3'b000): begin
                        bus.alu     = 1'b1;
                        bus.wb      = 1'b1;
                        bus.alu_ops = fn;
                        bus.imm     = (cls == 2'b01);
                     end
                     (grp == 3'b001): begin
                        bus.mr = 1'b1;
                        bus.wb = 1'b1;
                     end
                     (grp == 3'b010): bus.mw = 1'b1;
                     (grp == 3'b011): begin
                        bus.jmp      = 1'b1;
                        bus.flag_sel = fn[1:0];
                     end
                     (grp == 3'b100 && cls == 2'b00): bus.wb = 1'b1;
                     (grp == 3'b101): begin
                        bus.io_rd = ~fn[0];
                        bus.wb    = ~fn[0];
                        bus.io_wr = fn[0];
                     end
                     (grp == 3'b111): begin
                        bus.is_stack_op = 1'b1;
                        bus.stack_op    = fn[0];
                        bus.mr          = fn[0];
                        bus.wb          = fn[0];
                        bus.mw          = ~fn[0];
                     end
                     (grp == 3'b110 && cls == 2'b10): state_nxt = CALL_PC;
                     (grp == 3'b110 && cls == 2'b11):
                        state_nxt = fn[0] ? RTI_FLG : RET_PC;
                     default: bus.illegal = 1'b1;
                  endcase
               end
               if (state_nxt == IDLE && pend_now) state_nxt = INT_PC;
            end
         end
         CALL_PC, INT_PC: begin
            bus.mw          = 1'b1;
            bus.is_stack_op = 1'b1;
            bus.stack_pc    = 1'b1;
            bus.pc_word_sel = LAST - word_cnt;
            bus.int_ack     = (state == INT_PC) && (word_cnt == '0);
            if (last_word) begin
               if (state == INT_PC) begin
                  state_nxt = INT_FLG;
               end else begin
                  bus.jmp   = 1'b1;
                  state_nxt = pend_now ? INT_PC : IDLE;
               end
            end
         end
         INT_FLG: begin
            bus.mw          = 1'b1;
            bus.is_stack_op = 1'b1;
            bus.stack_flags = 1'b1;
            state_nxt       = INT_VEC;
         end
         INT_VEC: begin
            bus.load_vector = 1'b1;
            state_nxt       = pend_now ? INT_PC : IDLE;
         end
         RTI_FLG: begin
            bus.mr          = 1'b1;
            bus.is_stack_op = 1'b1;
            bus.stack_op    = 1'b1;
            bus.stack_flags = 1'b1;
            state_nxt       = RET_PC;
         end
         RET_PC: begin
            bus.mr          = 1'b1;
            bus.is_stack_op = 1'b1;
            bus.stack_op    = 1'b1;
            bus.stack_pc    = 1'b1;
            bus.pc_word_sel = word_cnt;
            if (last_word) begin
               bus.jmp   = 1'b1;
               state_nxt = pend_now ? INT_PC : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      bus.stall = rst_n && (state_nxt != IDLE);
   end

   always_comb begin
      word_cnt_nxt = '0;
      if (pc_state && state_nxt == state) word_cnt_nxt = word_cnt + 1'b1;
      // the request that starts INT_PC is consumed on entry
      int_pend_nxt = pend_now;
      if (state_nxt == INT_PC && state != INT_PC) int_pend_nxt = 1'b0;
   end
endmodule
